// File: rtl/ram_access_arbiter_if.sv
// Bus bundle between the RAM access arbiter, its requesters and the IO-module RAM.
// The arbiter uses the slave view; the requester/RAM side uses the master view.
interface ram_access_arbiter_if #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_REQ       = 3
);
  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ-1:0]               req_we;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr_rd1;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr_rd2;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr_wr;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata;
  logic [NUM_REQ-1:0]               gnt;
  logic                             rd_valid;
  logic [2:0]                       rd_id;
  logic [DATA_WIDTH-1:0]            rd_data1;
  logic [DATA_WIDTH-1:0]            rd_data2;
  logic                             clr_start;
  logic                             clr_busy;
  logic                             clr_done;
  logic                             ram_wr_enable;
  logic [ADDRESS_WIDTH-1:0]         ram_addr_rd1;
  logic [ADDRESS_WIDTH-1:0]         ram_addr_rd2;
  logic [ADDRESS_WIDTH-1:0]         ram_addr_wr;
  logic [DATA_WIDTH-1:0]            ram_data_in;
  logic [DATA_WIDTH-1:0]            ram_data_out1;
  logic [DATA_WIDTH-1:0]            ram_data_out2;

  modport slave (
    input  req, req_we, req_addr_rd1, req_addr_rd2, req_addr_wr, req_wdata,
    input  clr_start, ram_data_out1, ram_data_out2,
    output gnt, rd_valid, rd_id, rd_data1, rd_data2, clr_busy, clr_done,
    output ram_wr_enable, ram_addr_rd1, ram_addr_rd2, ram_addr_wr, ram_data_in
  );

  modport master (
    output req, req_we, req_addr_rd1, req_addr_rd2, req_addr_wr, req_wdata,
    output clr_start, ram_data_out1, ram_data_out2,
    input  gnt, rd_valid, rd_id, rd_data1, rd_data2, clr_busy, clr_done,
    input  ram_wr_enable, ram_addr_rd1, ram_addr_rd2, ram_addr_wr, ram_data_in
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters one RAM access per cycle,
// plus an on-demand zero-fill sweep of the whole RAM. Sole driver of the RAM.
module ram_access_arbiter #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_REQ       = 3,
  parameter int DEPTH         = 2**ADDRESS_WIDTH
) (
  input logic                CLK,
  input logic                RST,
  ram_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_CLEAR} state_e;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [2:0]               LAST_REQ  = 3'(NUM_REQ - 1);

  state_e                   state_q;
  logic [2:0]               ptr_q;
  logic [2:0]               grant_id_q;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q;
  logic [NUM_REQ-1:0]       gnt_q;
  logic                     rd_valid_q;
  logic [2:0]               rd_id_q;
  logic [DATA_WIDTH-1:0]    rd_data1_q;
  logic [DATA_WIDTH-1:0]    rd_data2_q;
  logic                     clr_busy_q;
  logic                     clr_done_q;
  logic                     ram_we_q;
  logic [ADDRESS_WIDTH-1:0] ram_addr_rd1_q;
  logic [ADDRESS_WIDTH-1:0] ram_addr_rd2_q;
  logic [ADDRESS_WIDTH-1:0] ram_addr_wr_q;
  logic [DATA_WIDTH-1:0]    ram_wdata_q;

  logic                     arb_found;
  logic [2:0]               arb_win;
  logic [NUM_REQ-1:0]       arb_onehot;
  logic [2:0]               ptr_d;
  logic                     sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr_rd1;
  logic [ADDRESS_WIDTH-1:0] sel_addr_rd2;
  logic [ADDRESS_WIDTH-1:0] sel_addr_wr;
  logic [DATA_WIDTH-1:0]    sel_wdata;

  // Two passes: first the requesters at or after the pointer, then the wrap-around.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    arb_found    = 1'b0;
    arb_win      = 3'd0;
    arb_onehot   = '0;
    sel_we       = 1'b0;
    sel_addr_rd1 = '0;
    sel_addr_rd2 = '0;
    sel_addr_wr  = '0;
    sel_wdata    = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!arb_found && bus.req[j] && (pass == 1 || 3'(j) >= ptr_q)) begin
          arb_found     = 1'b1;
          arb_win       = 3'(j);
          arb_onehot[j] = 1'b1;
          sel_we        = bus.req_we[j];
          sel_addr_rd1  = bus.req_addr_rd1[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          sel_addr_rd2  = bus.req_addr_rd2[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          sel_addr_wr   = bus.req_addr_wr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          sel_wdata     = bus.req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    ptr_d = (arb_win == LAST_REQ) ? 3'd0 : arb_win + 3'd1;
  end

  // NOTE: state is updated with non-blocking assignments only, so every register
  // samples the pre-edge values and read capture cannot race the RAM write.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= ST_IDLE;
      ptr_q          <= 3'd0;
      grant_id_q     <= 3'd0;
      clr_cnt_q      <= '0;
      gnt_q          <= '0;
      rd_valid_q     <= 1'b0;
      rd_id_q        <= 3'd0;
      rd_data1_q     <= '0;
      rd_data2_q     <= '0;
      clr_busy_q     <= 1'b0;
      clr_done_q     <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_rd1_q <= '0;
      ram_addr_rd2_q <= '0;
      ram_addr_wr_q  <= '0;
      ram_wdata_q    <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      clr_done_q <= 1'b0;

      // A grant in flight always returns its read data, even if a clear follows.
      if (state_q == ST_GRANT) begin
        rd_valid_q <= 1'b1;
        rd_id_q    <= grant_id_q;
        rd_data1_q <= bus.ram_data_out1;
        rd_data2_q <= bus.ram_data_out2;
      end

      case (state_q)
        ST_CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_q    <= ST_IDLE;
            ram_we_q   <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            clr_cnt_q     <= clr_cnt_q + 1'b1;
            ram_addr_wr_q <= clr_cnt_q + 1'b1;
          end
        end
        default: begin
          if (bus.clr_start) begin
            state_q       <= ST_CLEAR;
            gnt_q         <= '0;
            clr_busy_q    <= 1'b1;
            clr_cnt_q     <= '0;
            ram_we_q      <= 1'b1;
            ram_addr_wr_q <= '0;
            ram_wdata_q   <= '0;
          end else if (arb_found) begin
            state_q        <= ST_GRANT;
            gnt_q          <= arb_onehot;
            grant_id_q     <= arb_win;
            ptr_q          <= ptr_d;
            ram_we_q       <= sel_we;
            ram_addr_rd1_q <= sel_addr_rd1;
            ram_addr_rd2_q <= sel_addr_rd2;
            ram_addr_wr_q  <= sel_addr_wr;
            ram_wdata_q    <= sel_wdata;
          end else begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            ram_we_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_id         = rd_id_q;
  assign bus.rd_data1      = rd_data1_q;
  assign bus.rd_data2      = rd_data2_q;
  assign bus.clr_busy      = clr_busy_q;
  assign bus.clr_done      = clr_done_q;
  assign bus.ram_wr_enable = ram_we_q;
  assign bus.ram_addr_rd1  = ram_addr_rd1_q;
  assign bus.ram_addr_rd2  = ram_addr_rd2_q;
  assign bus.ram_addr_wr   = ram_addr_wr_q;
  assign bus.ram_data_in   = ram_wdata_q;

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Round-robin arbiter and sequencer for the IO module's dual-read/single-write RAM.
- Shares one RAM access per cycle among NUM_REQ requesters, e.g. the IO loader, the solver core and the result unloader.
- Also runs a zero-fill clear sweep over the whole RAM on demand, so the RAM's own bulk reset never has to be used at run time.
- Sits between the requesters and the RAM; it is the RAM's only driver.

Parameters:
ADDRESS_WIDTH, 13, RAM address width
DATA_WIDTH, 64, RAM word width
NUM_REQ, 3, number of requesters (2..8)
DEPTH, 2**ADDRESS_WIDTH, number of words swept by a clear

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-low reset
req  in  NUM_REQ  per-requester access request (level)
req_we  in  NUM_REQ  per-requester write enable for its access
req_addr_rd1  in  NUM_REQ*ADDRESS_WIDTH  read address 1; requester i at bits [i*AW +: AW]
req_addr_rd2  in  NUM_REQ*ADDRESS_WIDTH  read address 2, same packing
req_addr_wr  in  NUM_REQ*ADDRESS_WIDTH  write address, same packing
req_wdata  in  NUM_REQ*DATA_WIDTH  write data, same packing with DATA_WIDTH
gnt  out  NUM_REQ  registered one-hot grant; at most one bit high
rd_valid  out  1  read data valid
rd_id  out  3  index of the requester that owns rd_data1/rd_data2
rd_data1  out  DATA_WIDTH  registered read data, port 1
rd_data2  out  DATA_WIDTH  registered read data, port 2
clr_start  in  1  request a full-RAM zero fill
clr_busy  out  1  clear sweep in progress
clr_done  out  1  one-cycle pulse after the last word is cleared
ram_wr_enable  out  1  to RAM WR_Enable
ram_addr_rd1  out  ADDRESS_WIDTH  to RAM read address 1
ram_addr_rd2  out  ADDRESS_WIDTH  to RAM read address 2
ram_addr_wr  out  ADDRESS_WIDTH  to RAM write address
ram_data_in  out  DATA_WIDTH  to RAM write data
ram_data_out1  in  DATA_WIDTH  from RAM, combinational read 1
ram_data_out2  in  DATA_WIDTH  from RAM, combinational read 2

Behaviour:
- Reset: RST=0 sampled at a CLK rising edge forces:
  - state IDLE, priority pointer 0, clear counter 0;
  - gnt=0, rd_valid=0, rd_id=0, rd_data1/2=0, clr_busy=0, clr_done=0;
  - all latched access fields 0, so ram_wr_enable=0 on the next cycle.
  - Reset mid-grant or mid-clear abandons the operation; no clr_done is issued.
- States: IDLE, GRANT, CLEAR.
- IDLE (or GRANT) at edge t:
  - If clr_start=1, go to CLEAR; clear has priority over req.
  - Else if any req bit is set, select the first set bit at or after the pointer, searching modulo NUM_REQ.
  - Latch that requester's we, addresses and wdata; set gnt[w]=1 for cycle t+1; move the pointer to (w+1) mod NUM_REQ.
  - Else go to IDLE with gnt=0.
- GRANT cycle:
  - RAM is driven from the latched fields; ram_wr_enable = latched we.
  - Arbitration for the next cycle runs in the same cycle, so back-to-back grants are possible at one access per cycle.
  - A requester wanting a single access drops req during its gnt cycle. A requester holding req is served again per round-robin order.
- Read return:
  - ram_data_out1/2 are registered at the end of the GRANT cycle.
  - rd_valid=1 and rd_id=w for exactly one cycle, t+2.
  - Read latency from the arbitration edge is 2 cycles; rd_data holds its value until the next grant's data.
- Write/read same address in one access: read returns the old contents, because the RAM write lands at the edge.
- Idle RAM outputs: ram_wr_enable=0; addresses and data hold their last values.
- CLEAR:
  - clr_busy=1; ram_wr_enable=1, ram_addr_wr = counter, ram_data_in=0.
  - Counter steps 0..DEPTH-1, one word per cycle, with no wrap.
  - After address DEPTH-1 the state goes to IDLE, clr_busy=0 and clr_done pulses for 1 cycle.
  - A sweep is DEPTH cycles.
  - gnt stays 0 throughout; requests are held by the requesters (level) and are not lost. The pointer is unchanged.
  - clr_start during CLEAR is ignored.
  - A grant already issued in the cycle clr_start is sampled completes normally; CLEAR begins the following cycle.
  - rd_valid is never asserted for clear cycles.

Test Plan:
- Reset → all outputs 0: assert RST=0 for 2 cycles with req=3'b111; the next cycle after release, gnt must be 3'b001.
- Round-robin fairness: hold req=3'b111 for 6 cycles → gnt sequence 001, 010, 100, 001, 010, 100, one access per cycle.
- Write then read:
  - Requester 1 writes 64'hDEAD_BEEF_0000_0001 to 0x0A5 (single-shot).
  - Requester 2 then reads rd1=0x0A5, rd2=0x000.
  - Required: rd_valid two cycles after requester 2's arbitration edge, rd_id=2, rd_data1=64'hDEAD_BEEF_0000_0001, rd_data2=0.
- Clear priority:
  - clr_start and req=3'b010 in the same cycle → clr_busy for exactly 8192 cycles, gnt=0 throughout, ram_addr_wr 0..8191.
  - clr_done pulses once; gnt=3'b010 the cycle after clr_done.
  - A read of 0x0A5 then returns 0.
- Reset mid-clear: RST=0 at counter 100 → clr_busy=0 and ram_wr_enable=0 the next cycle, no clr_done, pointer reset to 0.
- Read-during-write: one access writes 64'h5 to 0x10 while rd1=0x10, old contents 64'h3 → rd_data1=64'h3; the next read of 0x10 returns 64'h5.
